// File: rtl/mips_pkg.sv
// mips_pkg: shared MULDIV op codes, FSM states and default datapath width
package mips_pkg;
   localparam int MD_DATA_W = 32;
   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_t;
   typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_t;
endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: radix-2 shift-add multiply / restoring divide engine on unsigned magnitudes
module muldiv_core #(
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic              is_div,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] acc,
   output logic [DATA_W-1:0] lo,
   output logic              last
);
   localparam int CW = $clog2(DATA_W) + 1;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] b_q;
   logic              div_q;
   logic [DATA_W:0]   sum, rem_t, diff;
   logic              ge;
   assign sum   = {1'b0, acc} + {1'b0, {DATA_W{lo[0]}} & b_q};
   assign rem_t = {acc, lo[DATA_W-1]};
   assign diff  = rem_t - {1'b0, b_q};
   assign ge    = rem_t >= {1'b0, b_q};
   assign last  = step && cnt == CW'(DATA_W - 1);
   // acc/lo hold {product} for multiply and {remainder, quotient} for divide
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         acc   <= '0;
         lo    <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
      end else if (load) begin
         cnt   <= '0;
         acc   <= '0;
         lo    <= a;
         b_q   <= b;
         div_q <= is_div;
      end else if (step) begin
         cnt <= cnt + 1'b1;
         if (div_q) begin
            acc <= ge ? diff[DATA_W-1:0] : rem_t[DATA_W-1:0];
            lo  <= {lo[DATA_W-2:0], ge};
         end else begin
            {acc, lo} <= {sum, lo[DATA_W-1:1]};
         end
      end
   end
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: EX-stage iterative mul/div with HI/LO registers and pipeline stall request
module ex_muldiv_unit
   import mips_pkg::*;
#(
   parameter int                DATA_W  = MD_DATA_W,
   parameter logic [DATA_W-1:0] DIV0_LO = '1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] rs_val,
   input  logic [DATA_W-1:0] rt_val,
   input  logic              flush,
   input  logic              hilo_rd,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              busy,
   output logic              done,
   output logic              stall_req
);
   md_state_t           state, state_nx;
   logic                accept, fix_wr, a_neg, b_neg, last;
   logic                q_neg, r_neg, div_q, bz_q;
   logic [DATA_W-1:0]   a_raw, abs_a, abs_b, acc, qlo, wr_hi, wr_lo;
   logic [2*DATA_W-1:0] prod;
   assign a_neg     = !op[0] && rs_val[DATA_W-1];
   assign b_neg     = !op[0] && rt_val[DATA_W-1];
   assign abs_a     = a_neg ? -rs_val : rs_val;
   assign abs_b     = b_neg ? -rt_val : rt_val;
   assign busy      = state != IDLE;
   assign accept    = state == IDLE && start && !flush && !op[2];
   assign fix_wr    = state == FIX && !flush;
   assign stall_req = busy && (start || hilo_rd);
   assign prod      = q_neg ? -{acc, qlo} : {acc, qlo};
   muldiv_core #(.DATA_W(DATA_W)) u_core (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .step   (state == CALC),
      .is_div (op[1]),
      .a      (abs_a),
      .b      (abs_b),
      .acc    (acc),
      .lo     (qlo),
      .last   (last)
   );
   // sign-corrected result; divide by zero returns the raw dividend in HI
   always_comb begin
      wr_hi = !div_q ? prod[2*DATA_W-1:DATA_W] : bz_q ? a_raw : r_neg ? -acc : acc;
      wr_lo = !div_q ? prod[DATA_W-1:0] : bz_q ? DIV0_LO : q_neg ? -qlo : qlo;
   end
   // next state: flush aborts any in-flight op back to IDLE
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE ? (accept ? CALC : IDLE) :
                 flush         ? IDLE :
                 state == CALC ? (last ? FIX : CALC) : IDLE;
   end
   // state register
   always_ff @(posedge clk) begin
      state <= rst ? IDLE : state_nx;
   end
   // capture op kind and result signs at issue
   always_ff @(posedge clk) begin
      if (rst) begin
         q_neg <= 1'b0;
         r_neg <= 1'b0;
         div_q <= 1'b0;
         bz_q  <= 1'b0;
         a_raw <= '0;
      end else if (accept) begin
         q_neg <= a_neg ^ b_neg;
         r_neg <= a_neg;
         div_q <= op[1];
         bz_q  <= rt_val == '0;
         a_raw <= rs_val;
      end
   end
   // HI/LO writes from FIX or single-cycle MTHI/MTLO, plus the done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
      end else begin
         done <= fix_wr;
         if (fix_wr) begin
            hi <= wr_hi;
            lo <= wr_lo;
         end else if (state == IDLE && start && !flush) begin
            if (op == MD_MTHI) hi <= rs_val;
            if (op == MD_MTLO) lo <= rs_val;
         end
      end
   end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed scoreboard bench for the EX-stage mul/div unit
module tb_ex_muldiv_unit;
   import mips_pkg::*;
   logic        clk = 1'b0;
   logic        rst, start, flush, hilo_rd;
   logic [2:0]  op;
   logic [31:0] rs_val, rt_val, hi, lo;
   logic        busy, done, stall_req;
   logic [63:0] sb[$];
   logic [31:0] m_hi, m_lo;
   int          checks = 0, failures = 0;
   ex_muldiv_unit dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .flush     (flush),
      .hilo_rd   (hilo_rd),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .done      (done),
      .stall_req (stall_req)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint xa, xb, q, r;
      logic [63:0] ua, ub;
      xa = longint'($signed(a));
      xb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (o)
         3'd0: return xa * xb;
         3'd1: return ua * ub;
         3'd2, 3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFFFFFF};
            if (o == 3'd2) begin
               q = xa / xb;
               r = xa % xb;
               return {r[31:0], q[31:0]};
            end
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_res);
      start = 1'b1;
      op = o;
      rs_val = a;
      rt_val = b;
      if (expect_res) sb.push_back(model(o, a, b));
   endtask
   task automatic wait_done(input string tag);
      int lat;
      bit got;
      logic [63:0] e;
      got = 1'b0;
      lat = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 1) chk({tag, "_busy"}, busy, 1);
         if (done) begin
            got = 1'b1;
            lat = c;
            break;
         end
      end
      chk({tag, "_done_seen"}, got, 1);
      if (got) begin
         chk({tag, "_latency"}, lat, 34);
         chk({tag, "_sb_nonempty"}, sb.size() > 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_hilo"}, {hi, lo}, e);
            {m_hi, m_lo} = e;
         end
      end
   endtask
   initial begin
      int dcnt;
      rst = 1'b1; start = 1'b0; flush = 1'b0; hilo_rd = 1'b0;
      op = 3'd0; rs_val = '0; rt_val = '0;
      m_hi = '0; m_lo = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_stall", stall_req, 0);
      // MULT -3*7 and done pulse width
      issue(MD_MULT, 32'hFFFFFFFD, 32'd7, 1);
      wait_done("mult_neg");
      chk("mult_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
      @(negedge clk);
      chk("done_pulse_width", done, 0);
      chk("idle_busy", busy, 0);
      // MULTU then back-to-back DIV issued on the done cycle
      issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
      wait_done("multu_max");
      chk("multu_const", {hi, lo}, 64'hFFFFFFFE_00000001);
      issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1);
      wait_done("div_neg_b2b");
      chk("div_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      issue(MD_DIVU, 32'd7, 32'd0, 1);
      wait_done("divu_zero");
      chk("divu_zero_const", {hi, lo}, 64'h00000007_FFFFFFFF);
      issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1);
      wait_done("div_ovf");
      chk("div_ovf_const", {hi, lo}, 64'h00000000_80000000);
      issue(MD_DIV, 32'hFFFFFFF0, 32'd0, 1);
      wait_done("div_zero_signed");
      // hilo_rd and start while busy
      @(negedge clk);
      issue(MD_MULT, 32'd5, 32'd6, 1);
      dcnt = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            dcnt = c;
            break;
         end
         chk("busy_hi_old", {hi, lo}, {m_hi, m_lo});
         if (c == 3) begin
            start = 1'b1;
            op = MD_MTHI;
            rs_val = 32'hDEADBEEF;
         end
         if (c == 5) hilo_rd = 1'b1;
         #1;
         if (c == 3 || c >= 5) chk("busy_stall", stall_req, 1);
      end
      chk("rd_latency", dcnt, 34);
      chk("rd_hilo", {hi, lo}, sb.size() > 0 ? sb[0] : 64'hx);
      if (sb.size() > 0) {m_hi, m_lo} = sb.pop_front();
      chk("rd_stall_clear", stall_req, 0);
      hilo_rd = 1'b0;
      // flush mid-DIV
      @(negedge clk);
      issue(MD_DIV, 32'd100, 32'd7, 0);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", busy, 0);
      chk("flush_hilo", {hi, lo}, {m_hi, m_lo});
      dcnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      chk("flush_no_done", dcnt, 0);
      chk("flush_hilo_late", {hi, lo}, {m_hi, m_lo});
      // flush and start together
      issue(MD_MULT, 32'd3, 32'd3, 0);
      flush = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      chk("flush_start_busy", busy, 0);
      // MTLO / MTHI / undefined op
      issue(MD_MTLO, 32'h1234, 32'd0, 0);
      @(negedge clk);
      start = 1'b0;
      m_lo = 32'h1234;
      chk("mtlo_lo", lo, m_lo);
      chk("mtlo_busy", busy, 0);
      chk("mtlo_done", done, 0);
      issue(MD_MTHI, 32'hCAFE0001, 32'd0, 0);
      @(negedge clk);
      start = 1'b0;
      m_hi = 32'hCAFE0001;
      chk("mthi_hilo", {hi, lo}, {m_hi, m_lo});
      issue(3'd6, 32'h5555, 32'd1, 0);
      @(negedge clk);
      start = 1'b0;
      chk("undef_busy", busy, 0);
      chk("undef_hilo", {hi, lo}, {m_hi, m_lo});
      // random mix, back-to-back
      for (int i = 0; i < 6; i++) begin
         issue(3'($urandom_range(0, 3)), $urandom, (i % 2) ? $urandom_range(1, 300) : $urandom, 1);
         wait_done("rand");
      end
      // reset mid-MULT
      @(negedge clk);
      issue(MD_MULT, 32'd9, 32'd9, 0);
      repeat (10) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_hilo", {hi, lo}, 64'd0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
      issue(MD_MULTU, 32'd12, 32'd11, 1);
      wait_done("after_rst");
      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
